// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the xorshift generator family:
//   - state_t       : generator FSM states
//   - SH32_* / SH64_*: default xorshift shift triples for 32/64-bit state
//   - xorshift_step : one xorshift iteration for any width up to 64 bits
// -----------------------------------------------------------------------------
package prng_pkg;

  typedef enum logic [1:0] {
    ST_STEP   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int SH32_A = 13;
  localparam int SH32_B = 17;
  localparam int SH32_C = 5;
  localparam int SH64_A = 13;
  localparam int SH64_B = 7;
  localparam int SH64_C = 17;

  // State is carried in the low 'width' bits of a 64-bit word. The left
  // shift is masked back to 'width' before the final right shift so that
  // bits pushed above the state never fold back into it.
  function automatic logic [63:0] xorshift_step(input logic [63:0] s,
                                                input int width,
                                                input int sh_a,
                                                input int sh_b,
                                                input int sh_c);
    logic [63:0] mask;
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    s0 = s & mask;
    s1 = s0 ^ (s0 >> sh_a);
    s2 = (s1 ^ (s1 << sh_b)) & mask;
    return s2 ^ (s2 >> sh_c);
  endfunction

endpackage

// File: rtl/prng_xorshift_gen_if.sv
// -----------------------------------------------------------------------------
// prng_xorshift_gen_if
// Sample output port of the generator.
//   out_valid : out_data holds a sample            (master -> slave)
//   out_ready : consumer accepts the sample        (slave  -> master)
//   out_data  : reduced sample, WIDTH bits         (master -> slave)
//   range_err : sample was produced from min > max (master -> slave)
// -----------------------------------------------------------------------------
interface prng_xorshift_gen_if #(
  parameter int WIDTH = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             range_err;

  modport master (output out_valid, output out_data, output range_err,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  range_err,
                  output out_ready);
endinterface

// File: rtl/prng_mod_reduce.sv
// -----------------------------------------------------------------------------
// prng_mod_reduce
// Iterative restoring remainder: o_rem = i_dividend mod i_span, one quotient
// bit per cycle MSB first, WIDTH cycles after i_start.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : load operands and begin (one cycle)
//   i_dividend  : WIDTH-bit dividend
//   i_span      : WIDTH+1-bit divisor (may be 2^WIDTH)
//   i_bypass    : return the dividend unchanged (span 2^WIDTH or invalid)
//   o_done      : high during the last iteration cycle
//   o_rem       : result, valid while o_done is high
// -----------------------------------------------------------------------------
module prng_mod_reduce #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH:0]   i_span,
  input  logic             i_bypass,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_span;
  logic             r_bypass;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;

  // Partial remainder is always < span <= 2^WIDTH, so the restored value
  // fits back into WIDTH bits.
  assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
  assign w_rem_nxt = WIDTH'((w_trial >= r_span) ? (w_trial - r_span) : w_trial);

  // o_rem is presented combinationally during the final iteration so the
  // caller can register the result on the same edge the iteration ends.
  assign o_done = r_busy && (r_cnt == LAST);
  assign o_rem  = r_bypass ? r_dvd : w_rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == LAST) r_busy <= 1'b0;
      else               r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_rem    <= '0;
      r_dvd    <= i_dividend;
      r_span   <= i_span;
      r_bypass <= i_bypass;
    end else if (r_busy && !r_bypass) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/prng_xorshift_gen.sv
// -----------------------------------------------------------------------------
// prng_xorshift_gen
// Registered xorshift PRNG with seed reload and valid/ready sample port.
// Optional feature macro PRNG_REDUCE_EN: when defined, each sample is reduced
// into the inclusive window [i_range_min, i_range_max] by a WIDTH-cycle
// divider; when undefined the raw state is emitted every second cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_seed_load   : one-cycle pulse, load i_seed_in (0 selects SEED)
//   i_seed_in     : new seed
//   i_range_min   : inclusive lower bound (sampled in STEP)
//   i_range_max   : inclusive upper bound (sampled in STEP)
//   o_busy        : generation/reduction in progress
//   bus (master)  : out_valid / out_ready / out_data / range_err
// -----------------------------------------------------------------------------
module prng_xorshift_gen
  import prng_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = 32'hDEADBEEF,
  parameter int          SH_A  = SH32_A,
  parameter int          SH_B  = SH32_B,
  parameter int          SH_C  = SH32_C
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_seed_load,
  input  logic [WIDTH-1:0]    i_seed_in,
  input  logic [WIDTH-1:0]    i_range_min,
  input  logic [WIDTH-1:0]    i_range_max,
  output logic                o_busy,
  prng_xorshift_gen_if.master bus
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  state_t           r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;

  assign w_next = WIDTH'(xorshift_step(64'(r_state), WIDTH, SH_A, SH_B, SH_C));
  // A zero state would lock xorshift at zero forever.
  assign w_seed = (i_seed_in == '0) ? SEED_W : i_seed_in;

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign o_busy        = r_busy;

`ifdef PRNG_REDUCE_EN
  logic             r_err;
  logic             r_bad;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH:0]   w_span;
  logic             w_bad;
  logic             w_start;
  logic             w_done;
  logic [WIDTH-1:0] w_rem;

  // span reaches 2^WIDTH only for the full window; the divider then simply
  // forwards the raw state. An inverted window forwards the raw state too.
  assign w_span  = {1'b0, i_range_max} - {1'b0, i_range_min} + (WIDTH+1)'(1);
  assign w_bad   = i_range_min > i_range_max;
  assign w_start = (r_fsm == ST_STEP) && !i_seed_load;

  assign bus.range_err = r_err;

  prng_mod_reduce #(.WIDTH(WIDTH)) u_reduce (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_dividend (w_next),
    .i_span     (w_span),
    .i_bypass   (w_bad | w_span[WIDTH]),
    .o_done     (w_done),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk) begin
    if (r_fsm == ST_STEP) r_min <= i_range_min;
  end
`else
  logic w_unused_range;
  assign w_unused_range = ^{i_range_min, i_range_max};
  assign bus.range_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_W;
      r_fsm   <= ST_STEP;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b1;
`ifdef PRNG_REDUCE_EN
      r_err   <= 1'b0;
      r_bad   <= 1'b0;
`endif
    end else if (i_seed_load) begin
      // Dropping out_valid here still lets a coincident transfer complete.
      r_state <= w_seed;
      r_fsm   <= ST_STEP;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_fsm)
        ST_STEP: begin
          r_state <= w_next;
`ifdef PRNG_REDUCE_EN
          r_err   <= 1'b0;
          r_bad   <= w_bad;
          r_fsm   <= ST_REDUCE;
`else
          r_data  <= w_next;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_fsm   <= ST_HOLD;
`endif
        end
`ifdef PRNG_REDUCE_EN
        ST_REDUCE: begin
          if (w_done) begin
            r_data  <= r_bad ? w_rem : (w_rem + r_min);
            r_err   <= r_bad;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_fsm   <= ST_HOLD;
          end
        end
`endif
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_fsm   <= ST_STEP;
          end
        end
        default: r_fsm <= ST_STEP;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_xorshift_gen.sv
module tb_prng_xorshift_gen;

  localparam int W = 32;
`ifdef PRNG_REDUCE_EN
  localparam bit RED = 1'b1;
  localparam int LAT = W + 1;
`else
  localparam bit RED = 1'b0;
  localparam int LAT = 1;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in   = '0;
  logic [W-1:0]  rmin      = '0;
  logic [W-1:0]  rmax      = '1;
  logic          busy;

  int checks = 0;
  int errors = 0;

  prng_xorshift_gen_if #(.WIDTH(W)) bus ();

  prng_xorshift_gen #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_seed_load (seed_load),
    .i_seed_in   (seed_in),
    .i_range_min (rmin),
    .i_range_max (rmax),
    .o_busy      (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] a;
    logic [31:0] b;
    a = s ^ (s >> 13);
    b = a ^ (a << 17);
    return b ^ (b >> 5);
  endfunction

  function automatic logic [31:0] model_out(input logic [31:0] raw,
                                            input logic [31:0] mn,
                                            input logic [31:0] mx);
    logic [32:0] span;
    if (!RED || mn > mx) return raw;
    span = {1'b0, mx} - {1'b0, mn} + 33'd1;
    if (span[32]) return raw;
    return 32'(({1'b0, raw} % span)) + mn;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 200);
  endtask

  task automatic reseed(input logic [W-1:0] s, input logic [W-1:0] mn, input logic [W-1:0] mx);
    seed_in   = s;
    rmin      = mn;
    rmax      = mx;
    seed_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        ok;
    logic [31:0] s;
    logic [31:0] d0;

    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data",  bus.out_data,  0);
    chk("rst_busy",  busy,          1);
    chk("rst_err",   bus.range_err, 0);

    // First sample after reset, full window.
    rst_n = 1'b1;
    wait_valid(n);
    chk("lat_reset",   n,             LAT);
    chk("first_data",  bus.out_data,  32'h4BE231DE);
    chk("first_busy",  busy,          0);
    chk("first_err",   bus.range_err, 0);

    // Back-pressure: hold for 50 cycles.
    d0 = bus.out_data;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0) ok = 1'b0;
    end
    chk("stall_stable", ok, 1);
    take();
    chk("drop_after_xfer", bus.out_valid, 0);
    wait_valid(n);
    chk("lat_next", n, LAT);
    s = xs32(32'h4BE231DE);
    chk("second_data", bus.out_data, s);

    // Throughput with ready held high.
    bus.out_ready = 1'b1;
    wait_valid(n);
    bus.out_ready = 1'b0;
    chk("period", n, LAT + 1);
    s = xs32(s);
    chk("third_data", bus.out_data, s);

    // Reload with zero seed, window 0..15.
    reseed(32'h0, 32'd0, 32'd15);
    chk("seed_drop", bus.out_valid, 0);
    wait_valid(n);
    chk("lat_seed", n, LAT);
    chk("mod16_data", bus.out_data, RED ? 32'hE : 32'h4BE231DE);

    // Reload with explicit SEED, window 100..109, then 1000 samples.
    reseed(32'hDEADBEEF, 32'd100, 32'd109);
    wait_valid(n);
    chk("mod10_data", bus.out_data, RED ? 32'd102 : 32'h4BE231DE);
    s = 32'h4BE231DE;
    ok = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wait_valid(n);
      s = xs32(s);
      if (n != LAT + 1 || bus.out_data !== model_out(s, 32'd100, 32'd109)) ok = 1'b0;
      if (RED && (bus.out_data < 32'd100 || bus.out_data > 32'd109)) ok = 1'b0;
    end
    bus.out_ready = 1'b0;
    chk("window_1000", ok, 1);

    // Reload in the middle of generation restarts the sequence.
    take();
    if (RED) repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    reseed(32'h0, 32'd0, 32'hFFFFFFFF);
    wait_valid(n);
    chk("mid_seed_lat",  n,            LAT);
    chk("mid_seed_data", bus.out_data, 32'h4BE231DE);

    // Inverted window.
    reseed(32'hDEADBEEF, 32'd20, 32'd10);
    wait_valid(n);
    chk("bad_data", bus.out_data,  32'h4BE231DE);
    chk("bad_err",  bus.range_err, RED ? 1 : 0);
    rmin = 32'd0;
    rmax = 32'd15;
    take();
    wait_valid(n);
    chk("fix_err",  bus.range_err, 0);
    chk("fix_data", bus.out_data,  model_out(xs32(32'h4BE231DE), 32'd0, 32'd15));

    // Asynchronous reset while a sample is presented.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data",  bus.out_data,  0);
    chk("arst_busy",  busy,          1);
    @(negedge clk);
    rmax  = 32'hFFFFFFFF;
    rst_n = 1'b1;
    wait_valid(n);
    chk("arst_lat",  n,            LAT);
    chk("arst_data2", bus.out_data, 32'h4BE231DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_xorshift_gen.md
# prng_xorshift_gen

Parametrised, clocked xorshift pseudo-random generator with seed reload, iterative range reduction to an inclusive [min, max] window and a valid/ready output port. It is the registered successor to the team's free-running combinational PRNG and feeds stimulus, noise and weight-initialisation consumers that need back-pressure and a runtime-selectable range.

## Interface
- WIDTH, 32: state/output width; legal values 32 or 64.
- SEED, 32'hDEADBEEF (zero-extended to WIDTH): reset state; must be nonzero.
- SH_A, 13: first right shift.
- SH_B, 17: left shift.
- SH_C, 5: second right shift.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  one-cycle pulse: load seed_in.
- seed_in  in  WIDTH  new seed.
- range_min  in  WIDTH  inclusive lower bound.
- range_max  in  WIDTH  inclusive upper bound.
- out_valid  out  1  out_data holds a sample.
- out_ready  in  1  consumer accepts the sample.
- out_data  out  WIDTH  reduced sample.
- busy  out  1  generation/reduction in progress.
- range_err  out  1  latched range had min > max.

## Operation
- FSM states: STEP, REDUCE, HOLD. Reset: state = SEED, FSM = STEP, out_valid = 0, out_data = 0, busy = 1, range_err = 0.
- STEP (1 cycle): state <= s3 where s1 = s ^ (s >> SH_A), s2 = s1 ^ (s1 << SH_B), s3 = s2 ^ (s2 >> SH_C), truncated to WIDTH; latch range_min/range_max; span = max - min + 1 in WIDTH+1 bits; go to REDUCE.
- REDUCE (exactly WIDTH cycles): restoring remainder of state mod span, one quotient bit per cycle, MSB first; go to HOLD.
- HOLD: out_valid = 1, out_data = remainder + min (WIDTH bits), busy = 0. On out_valid & out_ready go to STEP.
- Special cases, both keeping the same fixed latency: span = 2^WIDTH (min 0, max all ones) yields out_data = raw state; min > max yields out_data = raw state and range_err = 1 for that sample. range_err clears on the next STEP.
- seed_load (any state): state <= seed_in, or SEED if seed_in is 0; FSM <= STEP; out_valid drops the next cycle. If it coincides with an out_valid & out_ready transfer, the transfer still completes.
- Range inputs change only at STEP. Changes during REDUCE/HOLD apply to the next sample.

## Timing
- First out_valid rises WIDTH+1 rising edges after rst_n deassertion, or after a seed_load edge.
- With out_ready held high: one sample per WIDTH+2 cycles (HOLD, STEP, WIDTH×REDUCE).
- out_data and range_err are stable while out_valid = 1 and out_ready = 0.
- rst_n assertion mid-REDUCE/HOLD clears the outputs immediately (asynchronous). No partial sample is ever presented.

## Configuration
- PRNG_REDUCE_EN defined: behaviour as above.
- Undefined: no REDUCE state and no divider. Range ports are ignored. range_err is tied 0. out_data = raw state. Latency after reset/seed_load is 1 edge; throughput is one sample per 2 cycles.

## Structure
- Shared package prng_pkg holds:
  - the FSM state enum;
  - default shift constants (13/17/5 for 32-bit, 13/7/17 recommended for 64-bit);
  - the xorshift_step function, parametrised by WIDTH and the shifts.
- Sub-module prng_mod_reduce: iterative WIDTH-cycle restoring remainder with start/done and bypass for span = 2^WIDTH. It is reused by future range-limited blocks.

## Test plan
- Reset, WIDTH=32, min=0, max=32'hFFFFFFFF, out_ready=1 -> first out_data = 32'h4BE231DE, out_valid rises at edge 33.
- Same seed, min=0, max=15 -> out_data = 4'hE (0x4BE231DE mod 16).
- Same seed, min=100, max=109 -> out_data = 102. Next 1000 samples all within 100..109.
- out_ready held 0 for 50 cycles in HOLD -> out_data/out_valid stable; single transfer on release. Next sample is exactly WIDTH+2 cycles later.
- seed_load with seed_in=0 mid-REDUCE -> sequence restarts from SEED, first sample equals post-reset sample. seed_load with seed_in=32'hDEADBEEF gives the same result.
- min=20, max=10 -> range_err=1, out_data = raw state. Restoring a valid range clears range_err on the next sample. Mid-REDUCE rst_n pulse -> out_valid=0 immediately.
